// File: rtl/hazard_pkg.sv
// Shared hazard-unit definitions: FSM encoding, register address width, MDU latency default.
package hazard_pkg;

   localparam int REG_ADDR_W      = 5;
   localparam int MDU_LAT_DEFAULT = 4;
   localparam int MDU_CNT_W       = 4;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_MDU_WAIT   = 2'd2,
      ST_FLUSH      = 2'd3
   } hz_state_e;

   // $zero never carries a dependency, so a load targeting it cannot cause a stall.
   function automatic logic load_use_hit(input logic                  memread,
                                         input logic [REG_ADDR_W-1:0] ex_rt,
                                         input logic [REG_ADDR_W-1:0] id_rs,
                                         input logic [REG_ADDR_W-1:0] id_rt);
      return memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
   endfunction

endpackage

// File: rtl/mdu_wait_cnt.sv
// MDU wait counter: load, decrement, zero flag. zero_o reports that the counter
// holds zero after this edge (combinational, no backpressure).
module mdu_wait_cnt
   import hazard_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load_i,
   input  logic [MDU_CNT_W-1:0] load_val_i,
   input  logic                 dec_i,
   output logic                 zero_o
);

   logic [MDU_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign zero_o = (cnt_d == '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard FSM: load-use stall, branch flush, jump flush and (with HAZARD_CTRL_MDU_EN)
// an MDU_LAT-cycle multi-cycle freeze. Outputs are combinational from state and inputs.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MDU_LAT = MDU_LAT_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [REG_ADDR_W-1:0] ifid_rs_i,
   input  logic [REG_ADDR_W-1:0] ifid_rt_i,
   input  logic                  idex_memread_i,
   input  logic [REG_ADDR_W-1:0] idex_rt_i,
   input  logic                  branch_taken_i,
   input  logic                  jump_i,
   input  logic                  mdu_start_i,
   output logic                  pc_write_o,
   output logic                  ifid_write_o,
   output logic                  ifid_flush_o,
   output logic                  idex_bubble_o,
   output logic                  mdu_busy_o,
   output logic [1:0]            state_o
);

   hz_state_e state_q, state_d;
   logic      load_use;
   logic      cnt_load;
   logic      cnt_dec;
   logic      cnt_zero;

   assign load_use = load_use_hit(idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i);

`ifdef HAZARD_CTRL_MDU_EN
   mdu_wait_cnt u_mdu_wait_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (cnt_load),
      .load_val_i (MDU_CNT_W'(MDU_LAT - 1)),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );
`else
   logic unused_mdu;
   assign unused_mdu = mdu_start_i | cnt_load | cnt_dec | (MDU_LAT == 0);
   assign cnt_zero   = 1'b1;
`endif

   always_comb begin
      state_d       = state_q;
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      mdu_busy_o    = 1'b0;
      cnt_load      = 1'b0;
      cnt_dec       = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (branch_taken_i) begin
               ifid_flush_o  = 1'b1;
               idex_bubble_o = 1'b1;
               state_d       = ST_FLUSH;
            end else if (load_use) begin
               pc_write_o    = 1'b0;
               ifid_write_o  = 1'b0;
               idex_bubble_o = 1'b1;
               state_d       = ST_LOAD_STALL;
            end
`ifdef HAZARD_CTRL_MDU_EN
            // The mult/div itself issues into EX this cycle, so no bubble yet.
            else if (mdu_start_i) begin
               pc_write_o    = 1'b0;
               ifid_write_o  = 1'b0;
               cnt_load      = 1'b1;
               state_d       = ST_MDU_WAIT;
            end
`endif
            else if (jump_i) begin
               ifid_flush_o  = 1'b1;
            end
         end
         ST_LOAD_STALL: begin
            if (branch_taken_i) begin
               ifid_flush_o  = 1'b1;
               idex_bubble_o = 1'b1;
               state_d       = ST_FLUSH;
            end else begin
               state_d       = ST_RUN;
            end
         end
`ifdef HAZARD_CTRL_MDU_EN
         ST_MDU_WAIT: begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            mdu_busy_o    = 1'b1;
            cnt_dec       = 1'b1;
            if (cnt_zero) begin
               state_d = ST_RUN;
            end
         end
`endif
         ST_FLUSH: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      if (rst_i) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         ifid_flush_o  = 1'b0;
         idex_bubble_o = 1'b1;
         mdu_busy_o    = 1'b0;
         cnt_load      = 1'b0;
         cnt_dec       = 1'b0;
         state_d       = ST_RUN;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

   localparam int MDU_LAT = 4;
`ifdef HAZARD_CTRL_MDU_EN
   localparam bit MDU_EN = 1'b1;
`else
   localparam bit MDU_EN = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [4:0] ifid_rs_i, ifid_rt_i, idex_rt_i;
   logic       idex_memread_i, branch_taken_i, jump_i, mdu_start_i;
   logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, mdu_busy_o;
   logic [1:0] state_o;

   hazard_ctrl #(.MDU_LAT(MDU_LAT)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .ifid_rs_i      (ifid_rs_i),
      .ifid_rt_i      (ifid_rt_i),
      .idex_memread_i (idex_memread_i),
      .idex_rt_i      (idex_rt_i),
      .branch_taken_i (branch_taken_i),
      .jump_i         (jump_i),
      .mdu_start_i    (mdu_start_i),
      .pc_write_o     (pc_write_o),
      .ifid_write_o   (ifid_write_o),
      .ifid_flush_o   (ifid_flush_o),
      .idex_bubble_o  (idex_bubble_o),
      .mdu_busy_o     (mdu_busy_o),
      .state_o        (state_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;
   // Model: 0 run, 1 load stall, 2 mdu wait, 3 flush; m_left counts remaining wait cycles.
   int m_state = 0;
   int m_left  = 0;
   logic o_pc, o_busy, o_flush;
   logic [1:0] o_state;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Called just after a rising edge; applies inputs, checks at the falling edge, advances.
   task automatic step(input bit rst, input bit br, input bit mr, input bit [4:0] exrt,
                       input bit [4:0] rs, input bit [4:0] rt, input bit jmp, input bit mdu);
      bit lu;
      int e_pc, e_ifw, e_fl, e_bub, e_busy, nxt;
      rst_i = rst; branch_taken_i = br; idex_memread_i = mr; idex_rt_i = exrt;
      ifid_rs_i = rs; ifid_rt_i = rt; jump_i = jmp; mdu_start_i = mdu;

      lu = mr && (exrt != 0) && (exrt == rs || exrt == rt);
      e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_busy = 0; nxt = 0;
      if (rst) begin
         e_pc = 0; e_ifw = 0; e_bub = 1; m_state = 0; m_left = 0;
      end else begin
         case (m_state)
            0: begin
               if (br) begin e_fl = 1; e_bub = 1; nxt = 3; end
               else if (lu) begin e_pc = 0; e_ifw = 0; e_bub = 1; nxt = 1; end
               else if (mdu && MDU_EN) begin e_pc = 0; e_ifw = 0; nxt = 2; m_left = MDU_LAT - 1; end
               else if (jmp) e_fl = 1;
            end
            1: if (br) begin e_fl = 1; e_bub = 1; nxt = 3; end
            2: begin
               e_pc = 0; e_ifw = 0; e_bub = 1; e_busy = 1;
               m_left--;
               nxt = (m_left == 0) ? 0 : 2;
            end
            default: nxt = 0;
         endcase
      end

      @(negedge clk_i);
      chk("pc_write",    4'(pc_write_o),    4'(e_pc));
      chk("ifid_write",  4'(ifid_write_o),  4'(e_ifw));
      chk("ifid_flush",  4'(ifid_flush_o),  4'(e_fl));
      chk("idex_bubble", 4'(idex_bubble_o), 4'(e_bub));
      chk("mdu_busy",    4'(mdu_busy_o),    4'(e_busy));
      chk("state",       4'(state_o),       4'(m_state));
      o_pc = pc_write_o; o_busy = mdu_busy_o; o_flush = ifid_flush_o; o_state = state_o;
      @(posedge clk_i);
      #1;
      m_state = nxt;
   endtask

   task automatic idle();
      step(0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
   endtask

   initial begin
      int frz, bsy;
      bit [4:0] regs [4];
      regs[0] = 5'd0; regs[1] = 5'd8; regs[2] = 5'd9; regs[3] = 5'd10;

      rst_i = 1'b1; branch_taken_i = 0; idex_memread_i = 0; idex_rt_i = 0;
      ifid_rs_i = 0; ifid_rt_i = 0; jump_i = 0; mdu_start_i = 0;
      @(posedge clk_i); #1;
      step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      step(1, 1, 1, 5'd8, 5'd8, 5'd0, 1, 1);
      idle();

      // load-use on rs
      step(0, 0, 1, 5'd8, 5'd8, 5'd3, 0, 0);
      chk("lu_pc_frozen", 4'(o_pc), 4'd0);
      idle();
      chk("lu_then_stall", 4'(o_state), 4'd1);
      idle();
      chk("lu_then_run", 4'(o_state), 4'd0);

      // $zero destination never stalls
      step(0, 0, 1, 5'd0, 5'd5, 5'd0, 0, 0);
      chk("zero_no_stall", 4'(o_pc), 4'd1);
      idle();

      // branch beats load-use
      step(0, 1, 1, 5'd8, 5'd8, 5'd0, 0, 0);
      chk("prio_flush", 4'(o_flush), 4'd1);
      idle();
      chk("prio_flush_state", 4'(o_state), 4'd3);
      idle();

      // jump alone
      step(0, 0, 0, 5'd0, 5'd1, 5'd2, 1, 0);
      chk("jump_state", 4'(o_state), 4'd0);
      idle();
      chk("jump_one_cycle", 4'(o_flush), 4'd0);

      // MDU freeze length
      frz = 0; bsy = 0;
      step(0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 1);
      frz += (o_pc == 1'b0); bsy += o_busy;
      for (int i = 0; i < 8; i++) begin
         idle();
         frz += (o_pc == 1'b0); bsy += o_busy;
      end
      chk("mdu_freeze_cycles", 4'(frz), MDU_EN ? 4'(MDU_LAT) : 4'd0);
      chk("mdu_busy_cycles",   4'(bsy), MDU_EN ? 4'(MDU_LAT - 1) : 4'd0);

      // reset in second wait cycle
      step(0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 1);
      idle();
      step(1, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
      chk("rst_mid_bubble", 4'(o_pc), 4'd0);
      idle();
      chk("rst_release_state", 4'(o_state), 4'd0);

      for (int i = 0; i < 2500; i++) begin
         step($urandom_range(0, 63) == 0,
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 2) == 0,
              regs[$urandom_range(0, 3)],
              regs[$urandom_range(0, 3)],
              regs[$urandom_range(0, 3)],
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter: MDU_LAT, 4, multi-cycle unit latency in cycles (legal 2..15).
REQ-002 SHALL have port: clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: ifid_rs_i, ifid_rt_i  input  5 each  source register numbers of the ID-stage instruction.
REQ-005 SHALL have ports: idex_memread_i (input, 1, EX-stage instruction is a load) and idex_rt_i (input, 5, load destination register).
REQ-006 SHALL have port: branch_taken_i  input  1  branch resolved taken in EX.
REQ-007 SHALL have port: jump_i  input  1  jump decoded in ID.
REQ-008 SHALL have port: mdu_start_i  input  1  ID-stage instruction is a mult/div.
REQ-009 SHALL have ports: pc_write_o (output, 1, PC load enable) and ifid_write_o (output, 1, IF/ID load enable).
REQ-010 SHALL have ports: ifid_flush_o (output, 1, zero IF/ID) and idex_bubble_o (output, 1, load NOP controls and zero extended immediate into ID/EX).
REQ-011 SHALL have ports: mdu_busy_o (output, 1, MDU wait in progress) and state_o (output, 2, current FSM state for debug).

Function
REQ-012 SHALL implement FSM states RUN=0, LOAD_STALL=1, MDU_WAIT=2, FLUSH=3; outputs are combinational from state and inputs.
REQ-013 SHALL define load_use = idex_memread_i & (idex_rt_i!=0) & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i).
REQ-014 SHALL, in RUN with no event, drive pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, idex_bubble_o=0.
REQ-015 SHALL prioritise events in RUN: branch_taken_i > load_use > mdu_start_i > jump_i.
REQ-016 SHALL, on branch_taken_i in RUN or LOAD_STALL, drive pc_write_o=1, ifid_flush_o=1, idex_bubble_o=1 that cycle and go to FLUSH.
REQ-017 SHALL, on load_use in RUN, drive pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 that cycle and go to LOAD_STALL.
REQ-018 SHALL, in LOAD_STALL, ignore load_use, drive RUN-default outputs, and return to RUN after exactly one cycle.
REQ-019 SHALL, on mdu_start_i in RUN, load the wait counter with MDU_LAT-1, drive pc_write_o=0, ifid_write_o=0, idex_bubble_o=0 that cycle, and go to MDU_WAIT.
REQ-020 SHALL, in MDU_WAIT, hold pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, mdu_busy_o=1, and decrement the counter each cycle.
REQ-021 SHALL leave MDU_WAIT for RUN in the cycle after the counter reads 0; total PC freeze is MDU_LAT cycles.
REQ-022 SHALL ignore branch_taken_i, jump_i and load_use in MDU_WAIT (EX holds a bubble).
REQ-023 SHALL, in FLUSH, drive RUN-default outputs, ignore load_use, and return to RUN after one cycle.
REQ-024 SHALL, on jump_i in RUN with no higher event, drive ifid_flush_o=1 for that cycle only, with no state change.
REQ-025 SHALL drive mdu_busy_o=0 outside MDU_WAIT and state_o equal to the state encoding.

Reset
REQ-026 SHALL, while rst_i=1, force state RUN, counter 0, pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=1, mdu_busy_o=0.
REQ-027 SHALL, on reset asserted mid-stall (any state), abort immediately; after deassertion, the first edge starts in RUN.

Configuration
REQ-028 SHALL, with HAZARD_CTRL_MDU_EN defined, implement MDU_WAIT, the counter and REQ-019..021.
REQ-029 SHALL, without HAZARD_CTRL_MDU_EN, ignore mdu_start_i, tie mdu_busy_o to 0, and leave MDU_WAIT and the counter absent; an illegal state recovers to RUN.

Structure
REQ-030 SHALL take state encodings, REG_ADDR_W=5 and MDU_LAT_DEFAULT=4 from shared package hazard_pkg.
REQ-031 SHALL implement the wait counter as sub-module mdu_wait_cnt (load, decrement, zero flag), instantiated only under HAZARD_CTRL_MDU_EN.

Verification
REQ-032 SHALL check load-use: idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 -> one cycle with pc_write_o=0 and idex_bubble_o=1, then LOAD_STALL, then RUN.
REQ-033 SHALL check $zero: idex_memread_i=1, idex_rt_i=0, ifid_rt_i=0 -> no stall.
REQ-034 SHALL check MDU: with MDU_LAT=4, pulse mdu_start_i -> pc_write_o=0 for exactly 4 cycles and mdu_busy_o=1 for 3 cycles; macro off -> no stall.
REQ-035 SHALL check priority: branch_taken_i and load_use in the same cycle -> ifid_flush_o=1, pc_write_o=1, next state FLUSH.
REQ-036 SHALL check reset: rst_i raised in the 2nd MDU_WAIT cycle -> outputs take reset values immediately, and state_o=0 after release.
REQ-037 SHALL check jump: jump_i alone -> ifid_flush_o high for one cycle and state_o stays 0.
